// File: rtl/xoodoo_perm_ctrl_sca_pkg.sv
`default_nettype none
// ============================================================================
// xoodoo_perm_ctrl_sca_pkg : shared constants, FSM encoding, iteration count
// Revision: 1.0
// ============================================================================
package xoodoo_perm_ctrl_sca_pkg;

  localparam int STATE_W = 384;
  localparam int J_W     = 13;
  localparam int CNT_W   = 4;

  localparam logic [J_W-1:0] J_INIT = 13'h0001;

  // ST_FLUSH covers the single cycle of datapath register latency before DONE
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int calc_iter(input int rounds_per_cycle, input int num_rounds);
    return num_rounds / rounds_per_cycle;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xoodoo_perm_ctrl_sca_iter_cnt.sv
`default_nettype none
// ============================================================================
// xoodoo_iter_cnt : round-iteration counter with load, enable and last flag
// Revision: 1.0
// ============================================================================
module xoodoo_iter_cnt
  import xoodoo_perm_ctrl_sca_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(ITER - 1));

endmodule
`default_nettype wire

// File: rtl/xoodoo_perm_ctrl_sca.sv
`default_nettype none
// ============================================================================
// xoodoo_perm_ctrl_sca : masked Xoodoo permutation controller (two DOM shares)
// Optional abort input enabled by macro XOODOO_PERM_CTRL_ABORT_EN.
// Revision: 1.0
// ============================================================================
module xoodoo_perm_ctrl_sca
  import xoodoo_perm_ctrl_sca_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int NUM_ROUNDS       = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid_i,
  output logic               start_ready_o,
  input  logic [STATE_W-1:0] in_share0_i,
  input  logic [STATE_W-1:0] in_share1_i,
  input  logic               rnd_valid_i,
  input  logic [STATE_W-1:0] rnd_i,
  output logic               rnd_ready_o,
  output logic [STATE_W-1:0] dp_in0_o,
  output logic [STATE_W-1:0] dp_in1_o,
  output logic [STATE_W-1:0] dp_rs_o,
  input  logic [STATE_W-1:0] dp_out0_i,
  input  logic [STATE_W-1:0] dp_out1_i,
  output logic [J_W-1:0]     dp_j_o,
  input  logic [J_W-1:0]     dp_j_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] out_share0_o,
  output logic [STATE_W-1:0] out_share1_o,
  output logic               busy_o,
  output logic               rnd_err_o
`ifdef XOODOO_PERM_CTRL_ABORT_EN
  ,
  input  logic               abort_i
`endif
);

  localparam int ITER = calc_iter(ROUNDS_PER_CYCLE, NUM_ROUNDS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STATE_W-1:0] r_sh0;
  logic [STATE_W-1:0] r_sh1;
  logic [STATE_W-1:0] r_out0;
  logic [STATE_W-1:0] r_out1;
  logic               r_rnd_err;
  logic               w_abort;
  logic               w_cnt_load;
  logic               w_cnt_en;
  logic               w_cnt_last;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_first;

`ifdef XOODOO_PERM_CTRL_ABORT_EN
  assign w_abort = abort_i && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  xoodoo_iter_cnt #(
    .ITER (ITER)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt),
    .o_last (w_cnt_last)
  );

  assign w_first = (w_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_load    = 1'b0;
    w_cnt_en      = 1'b0;
    start_ready_o = 1'b0;
    busy_o        = 1'b1;
    rnd_ready_o   = 1'b0;
    out_valid_o   = 1'b0;
    dp_j_o        = '0;
    dp_rs_o       = '0;
    dp_in0_o      = '0;
    dp_in1_o      = '0;
    case (r_state)
      ST_IDLE: begin
        start_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (start_valid_i) begin
          w_state_nxt = ST_PREP;
        end
      end
      ST_PREP: begin
        // J_INIT only on the exit cycle, so the datapath's registered
        // constant stage holds it exactly during the first RUN iteration
        if (rnd_valid_i) begin
          dp_j_o      = J_INIT;
          w_cnt_load  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        rnd_ready_o = 1'b1;
        w_cnt_en    = 1'b1;
        dp_rs_o     = rnd_i;
        dp_j_o      = dp_j_i;
        dp_in0_o    = w_first ? r_sh0 : dp_out0_i;
        dp_in1_o    = w_first ? r_sh1 : dp_out1_i;
        if (w_cnt_last) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Share registers: each share has its own load path, never combined
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_sh0  <= '0;
      r_sh1  <= '0;
      r_out0 <= '0;
      r_out1 <= '0;
    end else if (r_state == ST_IDLE && start_valid_i) begin
      r_sh0 <= in_share0_i;
      r_sh1 <= in_share1_i;
    end else if (r_state == ST_FLUSH) begin
      r_out0 <= dp_out0_i;
      r_out1 <= dp_out1_i;
      r_sh0  <= '0;
      r_sh1  <= '0;
    end else if (r_state == ST_DONE && out_ready_i) begin
      r_out0 <= '0;
      r_out1 <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd_err <= 1'b0;
    end else if (r_state == ST_RUN && !rnd_valid_i) begin
      r_rnd_err <= 1'b1;
    end
  end

  assign out_share0_o = r_out0;
  assign out_share1_o = r_out1;
  assign rnd_err_o    = r_rnd_err;

endmodule
`default_nettype wire

// File: tb/tb_xoodoo_perm_ctrl_sca.sv
`default_nettype none
// Bench: two controller instances (1 and 3 rounds per iteration) on a toy
// share-wise datapath; every cycle is checked against a transaction model.
module tb_xoodoo_perm_ctrl_sca;
  import xoodoo_perm_ctrl_sca_pkg::*;

  localparam int NL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               sv[NL], sr[NL], rv[NL], rr[NL], ov[NL], ordy[NL], busy[NL], err[NL];
  logic [STATE_W-1:0] in0[NL], in1[NL], rnd[NL], di0[NL], di1[NL], drs[NL];
  logic [STATE_W-1:0] do0[NL], do1[NL], os0[NL], os1[NL];
  logic [J_W-1:0]     djo[NL], dji[NL];
`ifdef XOODOO_PERM_CTRL_ABORT_EN
  logic               ab[NL];
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input int ln, input string nm,
                     input logic [STATE_W-1:0] act, input logic [STATE_W-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lane%0d %s actual=%h required=%h", ln, nm, act, req);
    end
  endtask

  function automatic logic [STATE_W-1:0] rand384();
    logic [STATE_W-1:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int P  = (g == 0) ? 1 : 3;
    localparam int IT = 12 / P;

    logic [J_W-1:0]     r_j;
    logic [STATE_W-1:0] r_o0, r_o1;

    xoodoo_perm_ctrl_sca #(
      .ROUNDS_PER_CYCLE (P),
      .NUM_ROUNDS       (12)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_valid_i (sv[g]),
      .start_ready_o (sr[g]),
      .in_share0_i   (in0[g]),
      .in_share1_i   (in1[g]),
      .rnd_valid_i   (rv[g]),
      .rnd_i         (rnd[g]),
      .rnd_ready_o   (rr[g]),
      .dp_in0_o      (di0[g]),
      .dp_in1_o      (di1[g]),
      .dp_rs_o       (drs[g]),
      .dp_out0_i     (do0[g]),
      .dp_out1_i     (do1[g]),
      .dp_j_o        (djo[g]),
      .dp_j_i        (dji[g]),
      .out_valid_o   (ov[g]),
      .out_ready_i   (ordy[g]),
      .out_share0_o  (os0[g]),
      .out_share1_o  (os1[g]),
      .busy_o        (busy[g]),
      .rnd_err_o     (err[g])
`ifdef XOODOO_PERM_CTRL_ABORT_EN
      ,
      .abort_i       (ab[g])
`endif
    );

    // Toy registered datapath: the constant lands in share 0 only, the
    // randomness in both, so share0^share1 accumulates the constants alone
    always @(posedge clk) begin
      r_j  <= djo[g];
      r_o0 <= di0[g] ^ drs[g] ^ {{(STATE_W-J_W){1'b0}}, r_j};
      r_o1 <= di1[g] ^ drs[g];
    end
    assign do0[g] = r_o0;
    assign do1[g] = r_o1;
    assign dji[g] = r_j << P;

    // Transaction model: ph 0 idle, 1 waiting for randomness, 2 iterating,
    // 3 datapath latency, 4 result held
    int                 ph = 0;
    int                 ri = 0;
    bit                 armed = 1'b0;
    logic               m_err = 1'b0;
    logic [STATE_W-1:0] l0 = '0, l1 = '0, m0 = '0, m1 = '0;

    always @(negedge clk) begin
      int                 p0;
      logic [STATE_W-1:0] e0, e1, ej;
      if (armed) begin
        chk(sr[g] == (ph == 0), g, "start_ready", STATE_W'(sr[g]), STATE_W'(ph == 0));
        chk(busy[g] == (ph != 0), g, "busy", STATE_W'(busy[g]), STATE_W'(ph != 0));
        chk(ov[g] == (ph == 4), g, "out_valid", STATE_W'(ov[g]), STATE_W'(ph == 4));
        chk(rr[g] == (ph == 2), g, "rnd_ready", STATE_W'(rr[g]), STATE_W'(ph == 2));
        chk(err[g] == m_err, g, "rnd_err", STATE_W'(err[g]), STATE_W'(m_err));
        e0 = (ph == 2) ? rnd[g] : '0;
        chk(drs[g] == e0, g, "dp_rs", drs[g], e0);
        ej = (ph == 2) ? STATE_W'(dji[g]) : ((ph == 1 && rv[g]) ? STATE_W'(1) : '0);
        chk(STATE_W'(djo[g]) == ej, g, "dp_j", STATE_W'(djo[g]), ej);
        if (ph == 0 || ph == 2 || ph == 4) begin
          e0 = (ph == 2) ? ((ri == 0) ? l0 : do0[g]) : '0;
          e1 = (ph == 2) ? ((ri == 0) ? l1 : do1[g]) : '0;
          chk(di0[g] == e0, g, "dp_in0", di0[g], e0);
          chk(di1[g] == e1, g, "dp_in1", di1[g], e1);
        end
        if (ph == 0 || ph == 4) begin
          e0 = (ph == 4) ? m0 : '0;
          e1 = (ph == 4) ? m1 : '0;
          chk(os0[g] == e0, g, "out_share0", os0[g], e0);
          chk(os1[g] == e1, g, "out_share1", os1[g], e1);
        end
      end
      p0 = ph;
      if (rst) begin
        ph    = 0;
        m_err = 1'b0;
        armed = 1'b1;
      end else begin
        case (ph)
          0: if (sv[g]) begin
            ph = 1; l0 = in0[g]; l1 = in1[g]; m0 = in0[g]; m1 = in1[g];
          end
          1: if (rv[g]) begin
            ph = 2; ri = 0;
          end
          2: begin
            m0 = m0 ^ rnd[g] ^ {{(STATE_W-J_W){1'b0}}, J_W'(1 << (ri * P))};
            m1 = m1 ^ rnd[g];
            if (!rv[g]) m_err = 1'b1;
            ri++;
            if (ri == IT) ph = 3;
          end
          3: ph = 4;
          default: if (ordy[g]) ph = 0;
        endcase
`ifdef XOODOO_PERM_CTRL_ABORT_EN
        if (ab[g] && p0 != 0) ph = 0;
`endif
      end
    end
  end

  // Drives one permutation; timing decisions read DUT handshakes, never data
  task automatic run_perm(input int ln, input logic [STATE_W-1:0] s0, input logic [STATE_W-1:0] s1,
                          input int pdly, input int drop, input int odly,
                          output int bcnt, output int rcnt, output logic [STATE_W-1:0] x);
    int t, p;
    sv[ln] = 1'b1; in0[ln] = s0; in1[ln] = s1;
    @(posedge clk); #1;
    sv[ln] = 1'b0; in0[ln] = rand384(); in1[ln] = rand384();
    bcnt = 0; rcnt = 0; t = 0; p = 0;
    while (!ov[ln] && t < 100) begin
      if (busy[ln]) bcnt++;
      rnd[ln] = rand384();
      if (rr[ln]) begin
        rv[ln] = (rcnt != drop);
        rcnt++;
      end else if (busy[ln] && rcnt == 0) begin
        rv[ln] = (p >= pdly);
        p++;
      end else begin
        rv[ln] = $urandom_range(0, 1) == 1;
      end
      @(posedge clk); #1;
      t++;
    end
    chk(t < 100, ln, "done_timeout", STATE_W'(t), STATE_W'(100));
    x = os0[ln] ^ os1[ln];
    sv[ln] = 1'b1;
    for (int k = 0; k < odly; k++) begin
      @(posedge clk); #1;
    end
    sv[ln] = 1'b0; ordy[ln] = 1'b1;
    @(posedge clk); #1;
    ordy[ln] = 1'b0; rv[ln] = 1'b1;
  endtask

  initial begin
    logic [STATE_W-1:0] x, s0, s1, jx;
    int bc, rc, ln, pd, t, k;
    for (int i = 0; i < NL; i++) begin
      sv[i] = 0; rv[i] = 1; ordy[i] = 0; in0[i] = '0; in1[i] = '0; rnd[i] = '0;
`ifdef XOODOO_PERM_CTRL_ABORT_EN
      ab[i] = 0;
`endif
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Known answers of the toy datapath on a zero state
    run_perm(0, '0, '0, 0, -1, 0, bc, rc, x);
    chk(x == STATE_W'(13'h0FFF), 0, "kat_rpc1", x, STATE_W'(13'h0FFF));
    chk(bc == 14, 0, "busy_cycles_rpc1", STATE_W'(bc), STATE_W'(14));
    chk(rc == 12, 0, "rnd_ready_rpc1", STATE_W'(rc), STATE_W'(12));
    run_perm(1, '0, '0, 0, -1, 0, bc, rc, x);
    chk(x == STATE_W'(13'h0249), 1, "kat_rpc3", x, STATE_W'(13'h0249));
    chk(bc == 6, 1, "busy_cycles_rpc3", STATE_W'(bc), STATE_W'(6));
    chk(rc == 4, 1, "rnd_ready_rpc3", STATE_W'(rc), STATE_W'(4));

    // Randomness late by three cycles; DONE held ten cycles with start pending
    s0 = rand384(); s1 = rand384();
    run_perm(0, s0, s1, 3, -1, 10, bc, rc, x);
    chk(x == (s0 ^ s1 ^ STATE_W'(13'h0FFF)), 0, "late_rnd_result", x, s0 ^ s1 ^ STATE_W'(13'h0FFF));
    chk(bc == 17, 0, "late_rnd_busy", STATE_W'(bc), STATE_W'(17));
    chk(err[0] == 1'b0, 0, "late_rnd_err", STATE_W'(err[0]), '0);

    for (int i = 0; i < 10; i++) begin
      ln = i % NL;
      pd = $urandom_range(0, 3);
      jx = (ln == 0) ? STATE_W'(13'h0FFF) : STATE_W'(13'h0249);
      s0 = rand384(); s1 = rand384();
      run_perm(ln, s0, s1, pd, -1, $urandom_range(0, 4), bc, rc, x);
      chk(x == (s0 ^ s1 ^ jx), ln, "rand_result", x, s0 ^ s1 ^ jx);
      chk(bc == pd + ((ln == 0) ? 12 : 4) + 2, ln, "rand_busy", STATE_W'(bc),
          STATE_W'(pd + ((ln == 0) ? 12 : 4) + 2));
    end

    // Randomness dropped in RUN cycle 5: sticky error, no stall
    s0 = rand384(); s1 = rand384();
    run_perm(0, s0, s1, 0, 5, 0, bc, rc, x);
    chk(err[0] == 1'b1, 0, "drop_err", STATE_W'(err[0]), STATE_W'(1));
    chk(rc == 12, 0, "drop_no_stall", STATE_W'(rc), STATE_W'(12));
    run_perm(0, rand384(), rand384(), 1, -1, 0, bc, rc, x);
    chk(err[0] == 1'b1, 0, "drop_err_sticky", STATE_W'(err[0]), STATE_W'(1));

    // Reset in RUN cycle 6
    sv[0] = 1'b1; in0[0] = rand384(); in1[0] = rand384(); rv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    k = 0; t = 0;
    while (k < 6 && t < 50) begin
      if (rr[0]) k++;
      @(posedge clk); #1;
      t++;
    end
    chk(rr[0] == 1'b1, 0, "in_run_before_rst", STATE_W'(rr[0]), STATE_W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk(sr[0] == 1'b1 && busy[0] == 1'b0 && ov[0] == 1'b0 && err[0] == 1'b0, 0, "rst_ctrl",
        STATE_W'({sr[0], busy[0], ov[0], err[0]}), STATE_W'(4'b1000));
    chk((di0[0] | di1[0] | os0[0] | os1[0] | STATE_W'(djo[0])) == '0, 0, "rst_data",
        di0[0] | di1[0] | os0[0] | os1[0], '0);

`ifdef XOODOO_PERM_CTRL_ABORT_EN
    sv[0] = 1'b1; in0[0] = rand384(); in1[0] = rand384();
    @(posedge clk); #1;
    sv[0] = 1'b0;
    k = 0; t = 0;
    while (k < 2 && t < 50) begin
      if (rr[0]) k++;
      @(posedge clk); #1;
      t++;
    end
    ab[0] = 1'b1;
    @(posedge clk); #1;
    ab[0] = 1'b0;
    chk(busy[0] == 1'b0 && sr[0] == 1'b1, 0, "abort_idle", STATE_W'({busy[0], sr[0]}), STATE_W'(2'b01));
    for (int i = 0; i < 20; i++) begin
      chk(ov[0] == 1'b0, 0, "abort_no_valid", STATE_W'(ov[0]), '0);
      @(posedge clk); #1;
    end
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
